// File: rtl/OmpSsManager.sv
// Shared types and constants for the OmpSs manager command-in path.
package OmpSsManager;

   localparam int DEFAULT_MAX_ACCS     = 16;
   localparam int GRANT_ID_W           = $clog2(DEFAULT_MAX_ACCS);
   localparam int DEFAULT_STARVE_LIMIT = 4;
   localparam int STARVE_CNT_W         = 4;

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_SELECT,
      SCHED_OFFER,
      SCHED_WAIT_DONE
   } sched_state_t;

   // One grant handed to the command-in dispatcher.
   typedef struct packed {
      logic [GRANT_ID_W-1:0] acc_id;
      logic                  is_int;
   } sched_grant_t;

endpackage

// File: rtl/rr_find_first.sv
// Rotating find-first-set: returns the first set bit of mask at or above
// ptr, wrapping around modulo WIDTH.
module rr_find_first #(
   parameter  int WIDTH = 16,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] mask,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] pos;

   // Scan from the farthest offset down so the one nearest ptr wins last.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         pos = IDX_W'((int'(ptr) + k) % WIDTH);
         if (mask[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/cmd_in_sched.sv
// Command-in scheduler: picks the next accelerator and queue class
// (host or internal) for the command-in dispatcher, owns the availability
// and internal-not-empty bitmaps, and bounds starvation of host queues.
module cmd_in_sched
   import OmpSsManager::*;
#(
   parameter  int MAX_ACCS     = DEFAULT_MAX_ACCS,
   parameter  int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   localparam int ACC_BITS     = $clog2(MAX_ACCS)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                acc_avail_wr,
   input  logic [ACC_BITS-1:0] acc_avail_wr_address,
   input  logic                sched_queue_nempty_write,
   input  logic [ACC_BITS-1:0] sched_queue_nempty_address,
   output logic                grant_valid,
   input  logic                grant_ready,
   output logic [ACC_BITS-1:0] grant_acc_id,
   output logic                grant_int,
   input  logic                done_valid,
   input  logic                done_sent,
   input  logic                done_blocks,
   input  logic                done_int_empty,
   output logic                busy
);

   sched_state_t            state_q, state_d;
   logic [MAX_ACCS-1:0]     acc_avail_q, acc_avail_d;
   logic [MAX_ACCS-1:0]     int_nempty_q, int_nempty_d;
   logic [ACC_BITS-1:0]     rr_int_ptr_q, rr_ext_ptr_q;
   logic [STARVE_CNT_W-1:0] starve_cnt_q;
   sched_grant_t            grant_q;
   logic                    ext_seen_q;   // a host candidate was passed over

   logic                    int_found, ext_found;
   logic [ACC_BITS-1:0]     int_idx, ext_idx;
   logic [MAX_ACCS-1:0]     int_mask;
   logic                    pick_int, any_cand, done_acc;
   logic [ACC_BITS-1:0]     grant_id, next_ptr;

   assign int_mask = int_nempty_q & acc_avail_q;

   rr_find_first #(.WIDTH(MAX_ACCS)) u_int_ff (
      .mask  (int_mask),
      .ptr   (rr_int_ptr_q),
      .found (int_found),
      .idx   (int_idx)
   );

   rr_find_first #(.WIDTH(MAX_ACCS)) u_ext_ff (
      .mask  (acc_avail_q),
      .ptr   (rr_ext_ptr_q),
      .found (ext_found),
      .idx   (ext_idx)
   );

   assign pick_int = int_found & ((int'(starve_cnt_q) < STARVE_LIMIT) | ~ext_found);
   assign any_cand = int_found | ext_found;
   assign done_acc = (state_q == SCHED_WAIT_DONE) & done_valid;
   assign grant_id = ACC_BITS'(grant_q.acc_id);
   assign next_ptr = (grant_id == ACC_BITS'(MAX_ACCS - 1)) ? '0 : grant_id + ACC_BITS'(1);

   assign grant_acc_id = grant_id;
   assign grant_int    = grant_q.is_int;

   // Bitmap next-state: clears from the accepted done, sets from notifications; set wins.
   always_comb begin
      acc_avail_d  = acc_avail_q;
      int_nempty_d = int_nempty_q;
      if (done_acc && done_sent && done_blocks)
         acc_avail_d[grant_id] = 1'b0;
      if (done_acc && grant_q.is_int && done_int_empty)
         int_nempty_d[grant_id] = 1'b0;
      if (acc_avail_wr)
         acc_avail_d[acc_avail_wr_address] = 1'b1;
      if (sched_queue_nempty_write)
         int_nempty_d[sched_queue_nempty_address] = 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rstn) state_q <= SCHED_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SCHED_IDLE:      state_d = SCHED_SELECT;
         SCHED_SELECT:    if (any_cand) state_d = SCHED_OFFER;
         SCHED_OFFER:     if (grant_ready) state_d = SCHED_WAIT_DONE;
         SCHED_WAIT_DONE: if (done_valid) state_d = SCHED_IDLE;
         default:         state_d = SCHED_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      grant_valid = (state_q == SCHED_OFFER);
      busy        = (state_q == SCHED_OFFER) || (state_q == SCHED_WAIT_DONE);
   end

   // Bitmaps, grant register, round-robin pointers and starvation counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc_avail_q  <= '1;
         int_nempty_q <= '0;
         rr_int_ptr_q <= '0;
         rr_ext_ptr_q <= '0;
         starve_cnt_q <= '0;
         grant_q      <= '0;
         ext_seen_q   <= 1'b0;
      end else begin
         acc_avail_q  <= acc_avail_d;
         int_nempty_q <= int_nempty_d;
         if (state_q == SCHED_SELECT && any_cand) begin
            grant_q.acc_id <= GRANT_ID_W'(pick_int ? int_idx : ext_idx);
            grant_q.is_int <= pick_int;
            ext_seen_q     <= ext_found;
         end
         if (done_acc) begin
            if (grant_q.is_int) begin
               rr_int_ptr_q <= next_ptr;
               if (ext_seen_q && starve_cnt_q != '1)
                  starve_cnt_q <= starve_cnt_q + STARVE_CNT_W'(1);
            end else begin
               // Advances even when nothing was sent so empty host queues do not pin the pointer.
               rr_ext_ptr_q <= next_ptr;
               starve_cnt_q <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmd_in_sched.sv
// Directed bench for cmd_in_sched: stimulus pushes expected grants into a
// queue, an independent monitor pops and compares on each accepted grant.
module tb_cmd_in_sched;

   logic       clk = 1'b0;
   logic       rstn;
   logic       acc_avail_wr;
   logic [3:0] acc_avail_wr_address;
   logic       sched_queue_nempty_write;
   logic [3:0] sched_queue_nempty_address;
   logic       grant_valid;
   logic       grant_ready;
   logic [3:0] grant_acc_id;
   logic       grant_int;
   logic       done_valid;
   logic       done_sent;
   logic       done_blocks;
   logic       done_int_empty;
   logic       busy;

   typedef struct {
      logic [3:0] id;
      logic       is_int;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   cmd_in_sched #(.MAX_ACCS(16), .STARVE_LIMIT(4)) dut (
      .clk                        (clk),
      .rstn                       (rstn),
      .acc_avail_wr               (acc_avail_wr),
      .acc_avail_wr_address       (acc_avail_wr_address),
      .sched_queue_nempty_write   (sched_queue_nempty_write),
      .sched_queue_nempty_address (sched_queue_nempty_address),
      .grant_valid                (grant_valid),
      .grant_ready                (grant_ready),
      .grant_acc_id               (grant_acc_id),
      .grant_int                  (grant_int),
      .done_valid                 (done_valid),
      .done_sent                  (done_sent),
      .done_blocks                (done_blocks),
      .done_int_empty             (done_int_empty),
      .busy                       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted grant must match the oldest expected entry.
   always @(negedge clk) begin
      if (rstn && grant_valid && grant_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grant: got acc %0d int %0b, nothing expected", grant_acc_id, grant_int);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant_acc_id", 32'(grant_acc_id), 32'(e.id));
            check("grant_int", 32'(grant_int), 32'(e.is_int));
         end
      end
   end

   task automatic expect_grant(input logic [3:0] id, input logic is_int);
      exp_t e;
      e.id = id;
      e.is_int = is_int;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) for a handshake, returns just after the accepting edge.
   task automatic wait_handshake();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (grant_valid && grant_ready) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_timeout: got no grant handshake within 40 cycles, required one");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_done(input logic sent, input logic blocks, input logic int_empty,
                            input logic set_avail, input logic [3:0] set_addr);
      done_valid           = 1'b1;
      done_sent            = sent;
      done_blocks          = blocks;
      done_int_empty       = int_empty;
      acc_avail_wr         = set_avail;
      acc_avail_wr_address = set_addr;
      @(posedge clk);
      #1;
      done_valid     = 1'b0;
      done_sent      = 1'b0;
      done_blocks    = 1'b0;
      done_int_empty = 1'b0;
      acc_avail_wr   = 1'b0;
   endtask

   task automatic do_grant(input logic [3:0] id, input logic is_int,
                           input logic sent, input logic blocks, input logic int_empty);
      expect_grant(id, is_int);
      wait_handshake();
      send_done(sent, blocks, int_empty, 1'b0, 4'd0);
   endtask

   task automatic set_nempty(input logic [3:0] addr);
      sched_queue_nempty_write   = 1'b1;
      sched_queue_nempty_address = addr;
      @(posedge clk);
      #1;
      sched_queue_nempty_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      acc_avail_wr = 1'b0;
      acc_avail_wr_address = '0;
      sched_queue_nempty_write = 1'b0;
      sched_queue_nempty_address = '0;
      grant_ready = 1'b1;
      done_valid = 1'b0;
      done_sent = 1'b0;
      done_blocks = 1'b0;
      done_int_empty = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant_valid", 32'(grant_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant_acc_id", 32'(grant_acc_id), 0);
      check("rst_grant_int", 32'(grant_int), 0);
      check("rst_acc_avail", 32'(dut.acc_avail_q), 32'hFFFF);
      check("rst_int_nempty", 32'(dut.int_nempty_q), 0);

      // First grant two cycles after reset: host acc 0
      expect_grant(4'd0, 1'b0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("cycle1_no_grant", 32'(grant_valid), 0);
      @(posedge clk);
      #1;
      check("cycle2_grant_valid", 32'(grant_valid), 1);
      check("cycle2_busy", 32'(busy), 1);
      wait_handshake();
      check("wait_done_valid_low", 32'(grant_valid), 0);
      check("wait_done_busy", 32'(busy), 1);
      send_done(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("acc0_unavailable", 32'(dut.acc_avail_q[0]), 0);
      do_grant(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Internal request on acc 5, then back to host queues
      set_nempty(4'd5);
      do_grant(4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      check("int5_cleared", 32'(dut.int_nempty_q[5]), 0);
      check("starve_after_int5", 32'(dut.starve_cnt_q), 1);
      do_grant(4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      check("starve_reset_ext", 32'(dut.starve_cnt_q), 0);

      // Starvation bound: four internal grants, then a host grant
      set_nempty(4'd2);
      set_nempty(4'd3);
      do_grant(4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      do_grant(4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      do_grant(4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      do_grant(4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      check("starve_at_limit", 32'(dut.starve_cnt_q), 4);
      do_grant(4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      check("starve_cleared", 32'(dut.starve_cnt_q), 0);
      do_grant(4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      do_grant(4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      check("int_drained", 32'(dut.int_nempty_q), 0);

      // Back-pressure: grant held stable while notifications and a stray done arrive
      grant_ready = 1'b0;
      expect_grant(4'd4, 1'b0);
      for (int i = 0; i < 40 && !grant_valid; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         acc_avail_wr         = 1'b1;
         acc_avail_wr_address = 4'((i + 8) % 16);
         done_valid           = (i == 3);
         done_sent            = 1'b1;
         done_blocks          = 1'b1;
         @(negedge clk);
         check("stall_valid", 32'(grant_valid), 1);
         check("stall_acc_id", 32'(grant_acc_id), 4);
         check("stall_int", 32'(grant_int), 0);
      end
      @(posedge clk);
      #1;
      acc_avail_wr = 1'b0;
      done_valid   = 1'b0;
      done_sent    = 1'b0;
      done_blocks  = 1'b0;
      check("stray_done_ignored", 32'(dut.acc_avail_q[4]), 1);
      check("acc0_reavailable", 32'(dut.acc_avail_q[0]), 1);
      grant_ready = 1'b1;
      wait_handshake();
      send_done(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("acc4_unavailable", 32'(dut.acc_avail_q[4]), 0);

      // Same-cycle clear and set on acc 7: set wins
      do_grant(4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      do_grant(4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_grant(4'd7, 1'b0);
      wait_handshake();
      send_done(1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
      check("acc7_set_wins", 32'(dut.acc_avail_q[7]), 1);
      check("acc4_still_clear", 32'(dut.acc_avail_q[4]), 0);

      // Reset during WAIT_DONE, with done pulses arriving under reset
      expect_grant(4'd8, 1'b0);
      wait_handshake();
      rstn           = 1'b0;
      done_valid     = 1'b1;
      done_sent      = 1'b1;
      done_blocks    = 1'b1;
      done_int_empty = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("rst_mid_valid", 32'(grant_valid), 0);
         check("rst_mid_busy", 32'(busy), 0);
         check("rst_mid_acc_avail", 32'(dut.acc_avail_q), 32'hFFFF);
         check("rst_mid_int_nempty", 32'(dut.int_nempty_q), 0);
      end
      done_valid     = 1'b0;
      done_sent      = 1'b0;
      done_blocks    = 1'b0;
      done_int_empty = 1'b0;
      rstn           = 1'b1;
      do_grant(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
